// File: rtl/cpu_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package cpu_hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand EX forwarding select: MEM result beats WB result, $0 never forwarded.
module hazard_fwd_sel
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            sel
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet, so it can only be forwarded once in WB.
  assign mem_hit = mem_reg_write && !mem_mem_to_reg && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage MIPS pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 2,
  parameter int unsigned REG_ADDR_W        = 5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  mem_branch_taken,
  input  logic                  mem_jump,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       redirect;
  logic       load_use;
  logic [1:0] sel_a, sel_b;
  logic       unused_ok;

  // ex_reg_write is part of the EX control bundle but a load already implies it.
  assign unused_ok = ex_reg_write;

  assign redirect = mem_branch_taken | mem_jump;
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src            (ex_rs),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .sel            (sel_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src            (ex_rt),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .sel            (sel_b)
  );

  assign fwd_a_sel = arst_n ? sel_a : FWD_RF;
  assign fwd_b_sel = arst_n ? sel_b : FWD_RF;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!arst_n) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (!enable) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (redirect) begin
      // Wrong-path instructions in IF/ID/EX are squashed, abandoning any stall.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      cnt_d        = '0;
    end else if (state_q == STALL) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      if (cnt_q <= 2'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = STALL_INIT;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        stall_bubble;

  assign stall_bubble = ((state_q == STALL) || load_use) && !redirect;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (enable) begin
      if (stall_bubble && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
